// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
//
// General-purpose register file for the MIPS core: 32 x 32-bit registers,
// two combinational read ports (rs, rt) and one synchronous write port that
// takes a one-hot write select straight from the write-address decoder.
// Register 0 is hard-wired to zero.
//
// Ports
//   clk            in   1       rising-edge clock
//   rst            in   1       synchronous active-high reset, clears everything
//   ena            in   1       core enable; 0 freezes all state
//   we             in   1       write enable from write-back
//   one_hot_waddr  in   NREG    one-hot write select, bit i selects register i
//   wdata          in   DATA_W  write data
//   raddr1         in   5       rs read address
//   raddr2         in   5       rt read address
//   rdata1         out  DATA_W  rs read data (with same-cycle write bypass)
//   rdata2         out  DATA_W  rt read data (with same-cycle write bypass)
//   waddr_err      out  1       sticky: a write was attempted with a
//                               non-one-hot select; cleared only by rst
// -----------------------------------------------------------------------------
module regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              we,
    input  logic [NREG-1:0]   one_hot_waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [4:0]        raddr1,
    input  logic [4:0]        raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              waddr_err
);

    logic [DATA_W-1:0] reg_q [NREG];
    logic              waddr_err_q;
    logic              waddr_err_d;

    logic              wr_attempt;
    logic              sel_onehot;
    logic              wr_valid;
    logic [NREG-1:0]   wsel;

    // A write attempt is qualified by the core enable; the select must then
    // be exactly one-hot to be accepted.
    assign wr_attempt = ena & we;
    assign sel_onehot = $onehot(one_hot_waddr);
    assign wr_valid   = wr_attempt & sel_onehot;

    // Per-register write strobes. Bit 0 is masked so r0 can never be written
    // and never bypasses; a write aimed at r0 is simply dropped.
    always_comb begin
        wsel    = one_hot_waddr & {NREG{wr_valid}};
        wsel[0] = 1'b0;
    end

    // Error flag accumulates malformed attempts; frozen by ena like all state.
    assign waddr_err_d = waddr_err_q | (wr_attempt & ~sel_onehot);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                reg_q[i] <= '0;
            end
            waddr_err_q <= 1'b0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wsel[i]) begin
                    reg_q[i] <= wdata;
                end
            end
            if (ena) begin
                waddr_err_q <= waddr_err_d;
            end
        end
    end

    // Read muxes. A pending valid write to the addressed register is forwarded
    // so read-after-write has zero effective latency. wsel[0] is always 0, so
    // the r0 case falls through to the explicit zero.
    always_comb begin
        if (wsel[raddr1]) begin
            rdata1 = wdata;
        end else if (raddr1 == 5'd0) begin
            rdata1 = '0;
        end else begin
            rdata1 = reg_q[raddr1];
        end
    end

    always_comb begin
        if (wsel[raddr2]) begin
            rdata2 = wdata;
        end else if (raddr2 == 5'd0) begin
            rdata2 = '0;
        end else begin
            rdata2 = reg_q[raddr2];
        end
    end

    assign waddr_err = waddr_err_q;

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        we;
    logic [31:0] one_hot_waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        waddr_err;

    regfile #(.DATA_W(32), .NREG(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .we            (we),
        .one_hot_waddr (one_hot_waddr),
        .wdata         (wdata),
        .raddr1        (raddr1),
        .raddr2        (raddr2),
        .rdata1        (rdata1),
        .rdata2        (rdata2),
        .waddr_err     (waddr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] r1;
        logic [31:0] r2;
        logic        err;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor: outputs are combinational, so they are presented every cycle;
    // any expectations queued for this cycle are compared on the falling edge.
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (rdata1 === e.r1) n_pass++;
            else $display("FAIL %s rdata1: got %h expected %h", nm, rdata1, e.r1);
            n_checks++;
            if (rdata2 === e.r2) n_pass++;
            else $display("FAIL %s rdata2: got %h expected %h", nm, rdata2, e.r2);
            n_checks++;
            if (waddr_err === e.err) n_pass++;
            else $display("FAIL %s waddr_err: got %b expected %b", nm, waddr_err, e.err);
        end
    end

    task automatic drive(input logic r, input logic e, input logic w,
                         input logic [31:0] oh, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2);
        rst           = r;
        ena           = e;
        we            = w;
        one_hot_waddr = oh;
        wdata         = wd;
        raddr1        = a1;
        raddr2        = a2;
    endtask

    task automatic expect_out(input string nm, input logic [31:0] r1,
                              input logic [31:0] r2, input logic err);
        exp_t e;
        e.r1  = r1;
        e.r2  = r2;
        e.err = err;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1, 1, 0, 32'h0, 32'h0, 5'd0, 5'd0);
        step();
        step();

        // Reset state
        drive(0, 1, 0, 32'h0, 32'h0, 5'd5, 5'd31);
        expect_out("reset_state", 32'h0, 32'h0, 1'b0);
        step();

        // Preload r5, bypass visible on port 1 only
        drive(0, 1, 1, 32'h0000_0020, 32'h1234_5678, 5'd5, 5'd6);
        expect_out("preload_bypass", 32'h1234_5678, 32'h0, 1'b0);
        step();
        drive(0, 1, 0, 32'h0, 32'h0, 5'd5, 5'd6);
        expect_out("preload_held", 32'h1234_5678, 32'h0, 1'b0);
        step();

        // Reset with simultaneous write to r6: both lost/cleared
        drive(1, 1, 1, 32'h0000_0040, 32'hCAFE_F00D, 5'd5, 5'd6);
        step();
        drive(0, 1, 0, 32'h0, 32'h0, 5'd5, 5'd6);
        expect_out("reset_clears", 32'h0, 32'h0, 1'b0);
        step();

        // Write r31, no bypass on r30
        drive(0, 1, 1, 32'h8000_0000, 32'hDEAD_BEEF, 5'd30, 5'd30);
        expect_out("r31_write_r30", 32'h0, 32'h0, 1'b0);
        step();
        drive(0, 1, 0, 32'h0, 32'h0, 5'd31, 5'd31);
        expect_out("r31_read", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        step();
        drive(0, 1, 0, 32'h0, 32'h0, 5'd30, 5'd31);
        expect_out("r30_still_0", 32'h0, 32'hDEAD_BEEF, 1'b0);
        step();

        // r0 write dropped, no bypass, no error
        drive(0, 1, 1, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd0);
        expect_out("r0_write_cycle", 32'h0, 32'h0, 1'b0);
        step();
        drive(0, 1, 0, 32'h0, 32'h0, 5'd0, 5'd0);
        expect_out("r0_reads_0", 32'h0, 32'h0, 1'b0);
        step();

        // Bypass: preload r4, then we=0 shows old value, we=1 shows new
        drive(0, 1, 1, 32'h0000_0010, 32'h1357_9BDF, 5'd0, 5'd0);
        step();
        drive(0, 1, 0, 32'h0000_0010, 32'hA5A5_A5A5, 5'd4, 5'd4);
        expect_out("no_bypass_we0", 32'h1357_9BDF, 32'h1357_9BDF, 1'b0);
        step();
        drive(0, 1, 1, 32'h0000_0010, 32'hA5A5_A5A5, 5'd4, 5'd4);
        expect_out("bypass_both", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);
        step();
        drive(0, 0, 1, 32'h0000_0010, 32'h5A5A_5A5A, 5'd4, 5'd4);
        expect_out("no_bypass_ena0", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);
        step();
        drive(0, 1, 0, 32'h0, 32'h0, 5'd4, 5'd4);
        expect_out("r4_committed", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);
        step();

        // Malformed select: no write, no bypass, sticky error
        drive(0, 1, 1, 32'h0000_0030, 32'h1111_1111, 5'd4, 5'd5);
        expect_out("malformed_cycle", 32'hA5A5_A5A5, 32'h0, 1'b0);
        step();
        drive(0, 1, 0, 32'h0, 32'h0, 5'd4, 5'd5);
        expect_out("malformed_after", 32'hA5A5_A5A5, 32'h0, 1'b1);
        step();
        drive(0, 1, 1, 32'h0000_0000, 32'h3333_3333, 5'd4, 5'd5);
        expect_out("zero_select", 32'hA5A5_A5A5, 32'h0, 1'b1);
        step();
        drive(0, 1, 1, 32'h0000_0080, 32'h2222_2222, 5'd7, 5'd4);
        expect_out("err_sticky_byp", 32'h2222_2222, 32'hA5A5_A5A5, 1'b1);
        step();
        drive(0, 1, 0, 32'h0, 32'h0, 5'd7, 5'd4);
        expect_out("err_sticky", 32'h2222_2222, 32'hA5A5_A5A5, 1'b1);
        step();

        // Enable: ena=0 blocks the write, ena=1 lets it through
        drive(0, 0, 1, 32'h0000_0400, 32'h7777_7777, 5'd10, 5'd10);
        expect_out("ena0_write", 32'h0, 32'h0, 1'b1);
        step();
        drive(0, 1, 0, 32'h0, 32'h0, 5'd10, 5'd10);
        expect_out("ena0_unchanged", 32'h0, 32'h0, 1'b1);
        step();
        drive(0, 1, 1, 32'h0000_0400, 32'h7777_7777, 5'd10, 5'd10);
        expect_out("ena1_bypass", 32'h7777_7777, 32'h7777_7777, 1'b1);
        step();
        drive(0, 1, 0, 32'h0, 32'h0, 5'd10, 5'd10);
        expect_out("ena1_written", 32'h7777_7777, 32'h7777_7777, 1'b1);
        step();

        // Reset clears sticky error; ena=0 freezes it against a malformed select
        drive(1, 1, 0, 32'h0, 32'h0, 5'd10, 5'd10);
        step();
        drive(0, 0, 1, 32'h0000_0030, 32'h4444_4444, 5'd10, 5'd7);
        expect_out("err_cleared", 32'h0, 32'h0, 1'b0);
        step();
        drive(0, 1, 0, 32'h0, 32'h0, 5'd10, 5'd7);
        expect_out("ena0_err_frozen", 32'h0, 32'h0, 1'b0);
        step();

        // Reset has priority over ena=0
        drive(0, 1, 1, 32'h0000_0002, 32'h9999_0001, 5'd1, 5'd1);
        step();
        drive(1, 0, 0, 32'h0, 32'h0, 5'd1, 5'd1);
        expect_out("r1_before_rst", 32'h9999_0001, 32'h9999_0001, 1'b0);
        step();
        drive(0, 1, 0, 32'h0, 32'h0, 5'd1, 5'd1);
        expect_out("rst_over_ena0", 32'h0, 32'h0, 1'b0);
        step();

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
